// File: rtl/invader_grid_ctrl.sv
// Invader swarm grid controller: alive bitmap, per-pixel draw request and
// sprite offsets, single kill per frame, and swarm edge direction-change pulse.
module invader_grid_ctrl #(
   parameter int unsigned ROWS        = 4,
   parameter int unsigned COLS        = 8,
   parameter int unsigned CELL_W      = 32,
   parameter int unsigned CELL_H      = 32,
   parameter int unsigned RIGHT_LIMIT = 620,
   parameter int unsigned LEFT_LIMIT  = 0
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        startOfFrame,
   input  logic [10:0]                 pixelX,
   input  logic [10:0]                 pixelY,
   input  logic [10:0]                 topLeftX,
   input  logic [10:0]                 topLeftY,
   input  logic                        hitReq,
   input  logic                        restart,
   output logic                        drawReq,
   output logic [$clog2(CELL_W)-1:0]   offsetX,
   output logic [$clog2(CELL_H)-1:0]   offsetY,
   output logic [$clog2(ROWS)-1:0]     cellRow,
   output logic [$clog2(COLS)-1:0]     cellCol,
   output logic                        chgDir,
   output logic                        invaderHit,
   output logic [5:0]                  aliveCount,
   output logic                        allDead
);

   localparam int unsigned OX_W   = $clog2(CELL_W);
   localparam int unsigned OY_W   = $clog2(CELL_H);
   localparam int unsigned RW     = $clog2(ROWS);
   localparam int unsigned CW     = $clog2(COLS);
   localparam int unsigned N      = ROWS * COLS;
   localparam int unsigned IDX_W  = $clog2(N);
   localparam logic [5:0]  FULL_CNT = 6'(N);

   logic [N-1:0]      alive_q, alive_d;
   logic [5:0]        count_q, count_d;
   logic              dir_right_q, dir_right_d;
   logic              hit_lock_q, hit_lock_d;
   logic              inv_hit_q, inv_hit_d;
   logic              chg_dir_q, chg_dir_d;
   logic              draw_q;
   logic [OX_W-1:0]   off_x_q;
   logic [OY_W-1:0]   off_y_q;
   logic [RW-1:0]     row_q;
   logic [CW-1:0]     col_q;

   logic [11:0]       dx, dy;
   logic              in_grid;
   logic [RW-1:0]     row;
   logic [CW-1:0]     col;
   logic [IDX_W-1:0]  cell_idx;
   logic              cell_alive;
   logic              hit_ok;
   logic              all_dead;
   logic [COLS-1:0]   col_any;
   logic [CW-1:0]     lc, rc;
   logic [12:0]       right_edge, left_edge;

   // Pixel-to-cell mapping; a negative difference wraps high and fails the range test.
   always_comb begin
      dx         = {1'b0, pixelX} - {1'b0, topLeftX};
      dy         = {1'b0, pixelY} - {1'b0, topLeftY};
      in_grid    = (dx < 12'(COLS * CELL_W)) && (dy < 12'(ROWS * CELL_H));
      col        = dx[OX_W +: CW];
      row        = dy[OY_W +: RW];
      cell_idx   = IDX_W'(32'(row) * COLS + 32'(col));
      cell_alive = alive_q[cell_idx];
      all_dead   = (count_q == 6'd0);
      hit_ok     = hitReq && in_grid && cell_alive && !hit_lock_q && !restart;
   end

   // OR-scan of columns to find the leftmost and rightmost surviving columns.
   always_comb begin
      col_any = '0;
      for (int c = 0; c < int'(COLS); c++) begin
         for (int r = 0; r < int'(ROWS); r++) begin
            col_any[c] = col_any[c] | alive_q[r * int'(COLS) + c];
         end
      end
      lc = '0;
      rc = '0;
      for (int c = int'(COLS) - 1; c >= 0; c--) begin
         if (col_any[c]) lc = CW'(c);
      end
      for (int c = 0; c < int'(COLS); c++) begin
         if (col_any[c]) rc = CW'(c);
      end
      right_edge = 13'(topLeftX) + 13'((32'(rc) + 1) * CELL_W) - 13'd1;
      left_edge  = 13'(topLeftX) + 13'(32'(lc) * CELL_W);
   end

   // Next state for bitmap, kill lock and direction; restart overrides all.
   always_comb begin
      alive_d     = alive_q;
      count_d     = count_q;
      dir_right_d = dir_right_q;
      hit_lock_d  = hit_lock_q;
      inv_hit_d   = 1'b0;
      chg_dir_d   = 1'b0;
      if (restart) begin
         alive_d     = '1;
         count_d     = FULL_CNT;
         dir_right_d = 1'b1;
         hit_lock_d  = 1'b0;
      end else begin
         if (startOfFrame) hit_lock_d = 1'b0;
         // Kill after frame-start so the lock set wins over the clear.
         if (hit_ok) begin
            alive_d[cell_idx] = 1'b0;
            count_d           = count_q - 6'd1;
            inv_hit_d         = 1'b1;
            hit_lock_d        = 1'b1;
         end
         if (startOfFrame && !all_dead) begin
            if (dir_right_q && (right_edge >= 13'(RIGHT_LIMIT))) begin
               chg_dir_d   = 1'b1;
               dir_right_d = 1'b0;
            end else if (!dir_right_q && (left_edge <= 13'(LEFT_LIMIT))) begin
               chg_dir_d   = 1'b1;
               dir_right_d = 1'b1;
            end
         end
      end
   end

   // State and registered draw outputs; draw uses the pre-kill bitmap.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         alive_q     <= '1;
         count_q     <= FULL_CNT;
         dir_right_q <= 1'b1;
         hit_lock_q  <= 1'b0;
         inv_hit_q   <= 1'b0;
         chg_dir_q   <= 1'b0;
         draw_q      <= 1'b0;
         off_x_q     <= '0;
         off_y_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
      end else begin
         alive_q     <= alive_d;
         count_q     <= count_d;
         dir_right_q <= dir_right_d;
         hit_lock_q  <= hit_lock_d;
         inv_hit_q   <= inv_hit_d;
         chg_dir_q   <= chg_dir_d;
         draw_q      <= in_grid && cell_alive;
         off_x_q     <= dx[OX_W-1:0];
         off_y_q     <= dy[OY_W-1:0];
         row_q       <= row;
         col_q       <= col;
      end
   end

   assign drawReq    = draw_q;
   assign offsetX    = off_x_q;
   assign offsetY    = off_y_q;
   assign cellRow    = row_q;
   assign cellCol    = col_q;
   assign chgDir     = chg_dir_q;
   assign invaderHit = inv_hit_q;
   assign aliveCount = count_q;
   assign allDead    = all_dead;

endmodule

// File: tb/tb_invader_grid_ctrl.sv
// Directed self-checking bench for invader_grid_ctrl.
module tb_invader_grid_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
   logic        hitReq, restart;
   logic        drawReq;
   logic [4:0]  offsetX, offsetY;
   logic [1:0]  cellRow;
   logic [2:0]  cellCol;
   logic        chgDir, invaderHit;
   logic [5:0]  aliveCount;
   logic        allDead;

   int n_assert = 0;
   int n_fail   = 0;

   invader_grid_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .hitReq       (hitReq),
      .restart      (restart),
      .drawReq      (drawReq),
      .offsetX      (offsetX),
      .offsetY      (offsetY),
      .cellRow      (cellRow),
      .cellCol      (cellCol),
      .chgDir       (chgDir),
      .invaderHit   (invaderHit),
      .aliveCount   (aliveCount),
      .allDead      (allDead)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One startOfFrame pulse at swarm x; chgDir checked in the pulse cycle and after.
   task automatic frame(input logic [10:0] x, input logic exp_chg);
      topLeftX     = x;
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      chk("chgDir_frame", {31'd0, chgDir}, {31'd0, exp_chg});
      step();
      chk("chgDir_after", {31'd0, chgDir}, 32'd0);
   endtask

   task automatic hit(input int px, input int py);
      topLeftX = 11'd100;
      topLeftY = 11'd50;
      pixelX   = 11'(px);
      pixelY   = 11'(py);
      hitReq   = 1'b1;
      step();
      hitReq   = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_count", 32'(aliveCount), 32'd32);
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; hitReq = 1'b0; restart = 1'b0;
      pixelX = '0; pixelY = '0; topLeftX = 11'd100; topLeftY = 11'd50;
      #23;
      chk("rst_draw", {31'd0, drawReq}, 32'd0);
      chk("rst_count", 32'(aliveCount), 32'd32);
      chk("rst_alldead", {31'd0, allDead}, 32'd0);
      chk("rst_chg", {31'd0, chgDir}, 32'd0);
      chk("rst_hit", {31'd0, invaderHit}, 32'd0);
      chk("rst_offx", 32'(offsetX), 32'd0);
      chk("rst_col", 32'(cellCol), 32'd0);
      resetN = 1'b1;

      // Draw mapping
      pixelX = 11'd100; pixelY = 11'd50; step();
      chk("draw_tl", {31'd0, drawReq}, 32'd1);
      chk("draw_tl_ox", 32'(offsetX), 32'd0);
      chk("draw_tl_oy", 32'(offsetY), 32'd0);
      chk("draw_tl_row", 32'(cellRow), 32'd0);
      chk("draw_tl_col", 32'(cellCol), 32'd0);
      pixelX = 11'd355; pixelY = 11'd177; step();
      chk("draw_br", {31'd0, drawReq}, 32'd1);
      chk("draw_br_ox", 32'(offsetX), 32'd31);
      chk("draw_br_oy", 32'(offsetY), 32'd31);
      chk("draw_br_row", 32'(cellRow), 32'd3);
      chk("draw_br_col", 32'(cellCol), 32'd7);
      pixelX = 11'd356; pixelY = 11'd50; step();
      chk("draw_right_out", {31'd0, drawReq}, 32'd0);
      pixelX = 11'd99; step();
      chk("draw_left_out", {31'd0, drawReq}, 32'd0);

      // Kill and lock
      hit(140, 60);
      chk("kill1_pulse", {31'd0, invaderHit}, 32'd1);
      chk("kill1_count", 32'(aliveCount), 32'd31);
      step();
      chk("kill1_pulse_end", {31'd0, invaderHit}, 32'd0);
      chk("kill1_draw", {31'd0, drawReq}, 32'd0);
      hit(200, 60);
      chk("locked_pulse", {31'd0, invaderHit}, 32'd0);
      chk("locked_count", 32'(aliveCount), 32'd31);
      frame(11'd100, 1'b0);
      hit(200, 60);
      chk("kill2_pulse", {31'd0, invaderHit}, 32'd1);
      chk("kill2_count", 32'(aliveCount), 32'd30);
      step();
      frame(11'd100, 1'b0);
      hit(140, 60);
      chk("dead_cell_hit", {31'd0, invaderHit}, 32'd0);
      hit(50, 60);
      chk("outside_hit", {31'd0, invaderHit}, 32'd0);
      chk("ignored_count", 32'(aliveCount), 32'd30);

      // Edge detection, full grid
      do_restart();
      frame(11'd364, 1'b0);
      frame(11'd365, 1'b1);
      frame(11'd365, 1'b0);
      frame(11'd365, 1'b0);
      frame(11'd0, 1'b1);
      frame(11'd0, 1'b0);

      // Shrunk right edge: clear column 7
      for (int r = 0; r < 4; r++) begin
         frame(11'd100, 1'b0);
         hit(329, 55 + r * 32);
         chk("col7_kill", {31'd0, invaderHit}, 32'd1);
      end
      step();
      chk("col7_count", 32'(aliveCount), 32'd28);
      frame(11'd396, 1'b0);
      frame(11'd397, 1'b1);

      // Restart discards a simultaneous valid hit
      do_restart();
      for (int k = 0; k < 5; k++) begin
         frame(11'd100, 1'b0);
         hit(105 + k * 32, 55);
      end
      step();
      chk("five_kills", 32'(aliveCount), 32'd27);
      frame(11'd100, 1'b0);
      topLeftX = 11'd100; pixelX = 11'd265; pixelY = 11'd55;
      restart = 1'b1; hitReq = 1'b1;
      step();
      restart = 1'b0; hitReq = 1'b0;
      chk("rs_count", 32'(aliveCount), 32'd32);
      chk("rs_nohit", {31'd0, invaderHit}, 32'd0);
      step();
      chk("rs_nohit2", {31'd0, invaderHit}, 32'd0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            pixelX = 11'(110 + c * 32);
            pixelY = 11'(60 + r * 32);
            step();
            chk("rs_draw", {31'd0, drawReq}, 32'd1);
         end
      end

      // All dead
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            frame(11'd100, 1'b0);
            hit(105 + c * 32, 55 + r * 32);
            chk("ad_kill", {31'd0, invaderHit}, 32'd1);
         end
      end
      step();
      chk("ad_count", 32'(aliveCount), 32'd0);
      chk("ad_flag", {31'd0, allDead}, 32'd1);
      for (int x = 0; x <= 400; x++) begin
         topLeftX     = 11'(x);
         pixelX       = 11'(x + 5);
         pixelY       = 11'd55;
         startOfFrame = 1'b1;
         step();
         startOfFrame = 1'b0;
         step();
         chk("ad_sweep_chg", {31'd0, chgDir}, 32'd0);
         chk("ad_sweep_draw", {31'd0, drawReq}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/invader_grid_ctrl.md
Name: invader_grid_ctrl

Overview:
- Sits directly downstream of the invader movement block.
- Consumes the swarm's topLeftX/topLeftY and maintains the ROWS x COLS alive bitmap. Per pixel, it produces the draw request and sprite offsets for the invader bitmap ROM.
- Kills invaders on missile-collision requests.
- Generates the chgDir pulse fed back to the movement block whenever the leftmost or rightmost surviving column reaches a screen limit.

Parameters:
- ROWS, 4, invader rows.
- COLS, 8, invader columns.
- CELL_W, 32, cell width in pixels; power of 2.
- CELL_H, 32, cell height in pixels; power of 2.
- RIGHT_LIMIT, 620, rightmost allowed x of the swarm's alive edge.
- LEFT_LIMIT, 0, leftmost allowed x of the swarm's alive edge.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-clock pulse per frame.
- pixelX  in  11  current scan x.
- pixelY  in  11  current scan y.
- topLeftX  in  11  swarm top-left x, from the movement block.
- topLeftY  in  11  swarm top-left y.
- hitReq  in  1  missile/invader collision at current pixel.
- restart  in  1  new wave; refill the bitmap.
- drawReq  out  1  pixel is inside an alive cell (registered).
- offsetX  out  log2(CELL_W)  x offset inside cell.
- offsetY  out  log2(CELL_H)  y offset inside cell.
- cellRow  out  2  row index of the drawn cell.
- cellCol  out  3  column index of the drawn cell.
- chgDir  out  1  one-clock direction-change pulse.
- invaderHit  out  1  one-clock pulse, an invader was killed.
- aliveCount  out  6  surviving invaders.
- allDead  out  1  aliveCount == 0.

Behaviour:
- Reset values:
  - Bitmap all 1s.
  - aliveCount = ROWS*COLS (32).
  - drawReq, offsetX, offsetY, cellRow, cellCol, chgDir, invaderHit, allDead = 0.
  - Internal dirRight = 1; hitLock = 0.
- Grid membership (unsigned, 12-bit sums, no wrap):
  - inGrid = pixelX >= topLeftX and pixelX < topLeftX + COLS*CELL_W and pixelY >= topLeftY and pixelY < topLeftY + ROWS*CELL_H.
  - col = (pixelX - topLeftX) >> log2(CELL_W); row likewise.
  - offsets are the low bits of the differences.
- Draw path:
  - 1-clock latency: outputs registered from the inputs of the previous cycle.
  - drawReq = inGrid and alive[row][col], using the pre-update bitmap.
  - A kill and a draw in the same cycle: the draw still sees the invader alive.
  - offsetX, offsetY, cellRow, cellCol are registered every cycle, and are don't-care when drawReq = 0.
- Kill path:
  - Condition: hitReq and inGrid and alive[row][col] and !hitLock and !restart.
  - On the next clock: clear the bit, decrement aliveCount, pulse invaderHit for 1 clock, set hitLock.
  - hitLock clears on startOfFrame, so at most one kill per frame.
  - hitReq on a dead cell or outside the grid is ignored.
  - Kill and startOfFrame in the same cycle: the kill is taken and hitLock stays 1 (set has priority).
- Edge detect, evaluated in the cycle startOfFrame = 1; chgDir is registered and high the following cycle only:
  - Lc / Rc = lowest / highest column with any alive bit, from a combinational OR-scan.
  - rightEdge = topLeftX + (Rc+1)*CELL_W - 1; leftEdge = topLeftX + Lc*CELL_W.
  - If dirRight and rightEdge >= RIGHT_LIMIT: pulse chgDir and set dirRight = 0.
  - Else if !dirRight and leftEdge <= LEFT_LIMIT: pulse chgDir and set dirRight = 1.
  - Staying at the limit produces no further pulses until the opposite edge is reached.
  - No chgDir while allDead.
- restart (priority over everything except reset):
  - Next clock: bitmap all 1s, aliveCount = 32, dirRight = 1, hitLock = 0, invaderHit = 0, chgDir = 0.
  - A hit requested in the same cycle is discarded.
- allDead is combinational from the aliveCount register.

Test Plan:
- Draw mapping. topLeftX=100, topLeftY=50, full bitmap:
  - pixel (100,50) -> next clk drawReq=1, offset (0,0), row0 col0.
  - pixel (355,177) -> drawReq=1, offset (31,31), row3 col7.
  - pixel (356,50) and (99,50) -> drawReq=0.
- Kill and lock:
  - hitReq at (140,60) -> col1 row0 cleared, invaderHit 1 clk, aliveCount=31; later pixel (140,60) -> drawReq=0.
  - Second hitReq at (200,60) in the same frame -> ignored, count stays 31.
  - After startOfFrame, hitReq at (200,60) -> count=30.
- Edge, full grid:
  - topLeftX=364 at startOfFrame -> no pulse.
  - topLeftX=365 (rightEdge=620) -> chgDir 1 clk; repeating 365 for the next frames -> no pulse.
  - topLeftX=0 -> chgDir pulse; dirRight=1 again.
- Shrunk edge:
  - Kill all 4 invaders of column 7 over 4 frames.
  - topLeftX=396 -> no pulse; topLeftX=397 (rightEdge=620) -> chgDir.
- Restart:
  - After 5 kills, assert restart together with a valid hitReq -> aliveCount=32, invaderHit never pulses, all cells draw.
- All dead:
  - Kill all 32 over 32 frames -> allDead=1, aliveCount=0.
  - topLeftX swept 0..400 -> chgDir never pulses; drawReq always 0.
